fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. Drives the instruction-memory read request and holds the fetched word in the IF/ID output register, which feeds the control unit's `instr` input. Handles decode back-pressure (`stall`), branch/jump redirects (`flush`) and the halt opcode. Owns the program counter.

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage; owns the PC and the IF/ID register.
// Define FETCH_SKID_EN for a one-entry skid buffer that keeps imemREN high under stall.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] npc,
    output logic        instr_valid,
    output logic        halt_out
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
`ifdef FETCH_SKID_EN
        S_HOLD  = 2'd1,
`endif
        S_HALT  = 2'd2
    } state_t;

    localparam logic [5:0] HALT_OP = 6'b111111;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pc_inc;
    if_id_t      id_q, id_n, hit_word;
    logic        halt_q, halt_n;
    logic        ren;
    logic        is_halt;
`ifdef FETCH_SKID_EN
    if_id_t      skid_q, skid_n;
    logic        skid_is_halt;
`endif

    assign pc_inc   = pc + 32'd4;
    assign is_halt  = (iload[31:26] == HALT_OP);
    assign hit_word = '{instr: iload, pc: pc, npc: pc_inc, valid: 1'b1};

`ifdef FETCH_SKID_EN
    assign skid_is_halt = (skid_q.instr[31:26] == HALT_OP);
    assign ren = (state == S_FETCH);
`else
    assign ren = (state == S_FETCH) && !stall;
`endif

    assign imemREN     = nRST & ren;
    assign imemaddr    = pc;
    assign instr       = id_q.instr;
    assign pc_out      = id_q.pc;
    assign npc         = id_q.npc;
    assign instr_valid = id_q.valid;
    assign halt_out    = halt_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= S_FETCH;
            pc     <= PC_INIT;
            id_q   <= '0;
            halt_q <= 1'b0;
`ifdef FETCH_SKID_EN
            skid_q <= '0;
`endif
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            id_q   <= id_n;
            halt_q <= halt_n;
`ifdef FETCH_SKID_EN
            skid_q <= skid_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        id_n    = id_q;
        halt_n  = halt_q;
`ifdef FETCH_SKID_EN
        skid_n  = skid_q;
`endif
        if (flush) begin
            // redirect wins over stall and discards any same-cycle hit
            pc_n    = redirect_pc;
            id_n    = '0;
            halt_n  = 1'b0;
            state_n = S_FETCH;
`ifdef FETCH_SKID_EN
            skid_n  = '0;
`endif
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!stall) begin
                        if (ihit) begin
                            id_n = hit_word;
                            if (is_halt) begin
                                halt_n  = 1'b1;
                                state_n = S_HALT;
                            end else begin
                                pc_n = pc_inc;
                            end
                        end else begin
                            id_n = '0;
                        end
                    end
`ifdef FETCH_SKID_EN
                    else if (ihit) begin
                        // park the word; a parked halt still stops fetch now
                        skid_n  = hit_word;
                        state_n = S_HOLD;
                        if (is_halt) begin
                            halt_n = 1'b1;
                        end else begin
                            pc_n = pc_inc;
                        end
                    end
`endif
                end
`ifdef FETCH_SKID_EN
                S_HOLD: begin
                    if (!stall) begin
                        id_n    = skid_q;
                        skid_n  = '0;
                        state_n = skid_is_halt ? S_HALT : S_FETCH;
                    end
                end
`endif
                S_HALT: begin
                    if (!stall) begin
                        id_n = '0;
                    end
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed literal checks, then randomized traffic compared
// every cycle against a behavioural fetch model.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0100;
`ifdef FETCH_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] iload = '0;
    logic [31:0] redirect_pc = '0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] npc;
    logic        instr_valid;
    logic        halt_out;

    int errors = 0;
    int checks = 0;

    // model: PC, visible IF/ID word, halted flag, skid occupancy
    logic [31:0] m_pc, m_instr, m_pco, m_npc;
    logic        m_valid, m_halt, m_stop, m_full;
    logic [31:0] k_instr, k_pc, k_npc;
    logic        m_live = 1'b0;

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .ihit(ihit),
        .iload(iload),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .stall(stall),
        .flush(flush),
        .redirect_pc(redirect_pc),
        .instr(instr),
        .pc_out(pc_out),
        .npc(npc),
        .instr_valid(instr_valid),
        .halt_out(halt_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0001 + ((a - 32'h100) >> 2);
    endfunction

    function automatic logic ren_model(input logic rn, input logic st);
        return rn && !m_stop && !m_full && (SKID || !st);
    endfunction

    function automatic logic is_halt_op(input logic [31:0] w);
        return w[31:26] == 6'b111111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (!nRST) begin
            m_pc <= PC_INIT;
            m_instr <= '0; m_pco <= '0; m_npc <= '0; m_valid <= 1'b0;
            m_halt <= 1'b0; m_stop <= 1'b0; m_full <= 1'b0;
            m_live <= 1'b1;
        end else if (flush) begin
            m_pc <= redirect_pc;
            m_instr <= '0; m_pco <= '0; m_npc <= '0; m_valid <= 1'b0;
            m_halt <= 1'b0; m_stop <= 1'b0; m_full <= 1'b0;
        end else if (m_full) begin
            if (!stall) begin
                m_instr <= k_instr; m_pco <= k_pc; m_npc <= k_npc;
                m_valid <= 1'b1; m_full <= 1'b0;
            end
        end else if (m_stop) begin
            if (!stall) begin
                m_instr <= '0; m_pco <= '0; m_npc <= '0; m_valid <= 1'b0;
            end
        end else if (!stall) begin
            if (ihit) begin
                m_instr <= iload; m_pco <= m_pc; m_npc <= m_pc + 32'd4;
                m_valid <= 1'b1;
                if (is_halt_op(iload)) begin
                    m_halt <= 1'b1; m_stop <= 1'b1;
                end else begin
                    m_pc <= m_pc + 32'd4;
                end
            end else begin
                m_instr <= '0; m_pco <= '0; m_npc <= '0; m_valid <= 1'b0;
            end
        end else if (SKID && ihit) begin
            k_instr <= iload; k_pc <= m_pc; k_npc <= m_pc + 32'd4;
            m_full <= 1'b1;
            if (is_halt_op(iload)) begin
                m_halt <= 1'b1; m_stop <= 1'b1;
            end else begin
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("imemaddr", imemaddr, m_pc);
            chk("imemREN", {31'd0, imemREN}, {31'd0, ren_model(nRST, stall)});
            chk("instr", instr, m_instr);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            chk("halt_out", {31'd0, halt_out}, {31'd0, m_halt});
            if (m_valid) begin
                chk("pc_out", pc_out, m_pco);
                chk("npc", npc, m_npc);
            end
        end
    end

    task automatic cyc(input logic rn, input logic st, input logic hit,
                       input logic fl, input logic [31:0] ld,
                       input logic [31:0] rpc);
        nRST = rn; stall = st; ihit = hit; flush = fl;
        iload = ld; redirect_pc = rpc;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic        rn, st, hit, fl;
        logic [31:0] ld, rpc, r;

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_ren", {31'd0, imemREN}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_npc", npc, 32'd0);
        chk("rst_halt", {31'd0, halt_out}, 32'd0);
        chk("rst_addr", imemaddr, 32'h100);

        cyc(1, 0, 1, 0, 32'h2000_0001, 0);
        chk("f1_instr", instr, 32'h2000_0001);
        chk("f1_pc_out", pc_out, 32'h100);
        chk("f1_npc", npc, 32'h104);
        chk("f1_valid", {31'd0, instr_valid}, 32'd1);
        chk("f1_addr", imemaddr, 32'h104);
        cyc(1, 0, 1, 0, 32'h2000_0002, 0);
        chk("f2_instr", instr, 32'h2000_0002);
        chk("f2_addr", imemaddr, 32'h108);
        cyc(1, 0, 1, 0, 32'h2000_0003, 0);
        chk("f3_addr", imemaddr, 32'h10C);

        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        chk("bub_valid", {31'd0, instr_valid}, 32'd0);
        chk("bub_instr", instr, 32'd0);
        chk("bub_addr", imemaddr, 32'h10C);

        cyc(1, 0, 1, 0, 32'h2000_0004, 0);
        chk("f4_pc_out", pc_out, 32'h10C);

        cyc(1, 1, SKID, 0, 32'h2000_0005, 0);
        chk("st1_instr", instr, 32'h2000_0004);
        chk("st1_pc_out", pc_out, 32'h10C);
        chk("st1_ren", {31'd0, imemREN}, 32'd0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("st2_instr", instr, 32'h2000_0004);
        cyc(1, 0, !SKID, 0, 32'h2000_0005, 0);
        chk("rel_instr", instr, 32'h2000_0005);
        chk("rel_pc_out", pc_out, 32'h110);
        chk("rel_addr", imemaddr, 32'h114);
        cyc(1, 0, 1, 0, 32'h2000_0006, 0);
        chk("next_pc_out", pc_out, 32'h114);

        cyc(1, 0, 1, 1, 32'h2000_0007, 32'h400);
        chk("fl_addr", imemaddr, 32'h400);
        chk("fl_valid", {31'd0, instr_valid}, 32'd0);

        cyc(1, 0, 1, 0, 32'hFC00_0000, 0);
        chk("h_halt", {31'd0, halt_out}, 32'd1);
        chk("h_instr", instr, 32'hFC00_0000);
        chk("h_pc_out", pc_out, 32'h400);
        chk("h_addr", imemaddr, 32'h400);
        chk("h_ren", {31'd0, imemREN}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("h_bub_valid", {31'd0, instr_valid}, 32'd0);
        chk("h_still", {31'd0, halt_out}, 32'd1);
        cyc(1, 0, 0, 1, 0, 32'h200);
        chk("hf_halt", {31'd0, halt_out}, 32'd0);
        chk("hf_addr", imemaddr, 32'h200);
        chk("hf_ren", {31'd0, imemREN}, 32'd1);

        cyc(1, 0, 0, 1, 0, 32'hFFFF_FFFC);
        cyc(1, 0, 1, 0, 32'h2000_0008, 0);
        chk("wrap_addr", imemaddr, 32'd0);
        chk("wrap_npc", npc, 32'd0);
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);

        cyc(1, 1, SKID, 0, 32'h2000_0009, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("rst2_instr", instr, 32'd0);
        chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst2_pc_out", pc_out, 32'd0);
        chk("rst2_npc", npc, 32'd0);
        chk("rst2_addr", imemaddr, 32'h100);
        chk("rst2_ren", {31'd0, imemREN}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rn  = ($urandom_range(63) != 0);
            fl  = ($urandom_range(9) == 0);
            st  = ($urandom_range(3) == 0);
            hit = ren_model(rn, st) && ($urandom_range(3) != 0);
            r   = $urandom();
            if ($urandom_range(19) == 0)
                ld = {6'b111111, r[25:0]};
            else
                ld = mem_word(m_pc);
            if ($urandom_range(7) == 0)
                rpc = 32'hFFFF_FFF8;
            else
                rpc = PC_INIT + ($urandom_range(255) << 2);
            cyc(rn, st, hit, fl, ld, rpc);
        end

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
